hazard_sequencer: RTL and testbench

- Pipeline sequencing controller for the 5-stage core; sits beside the ALU operand bypass unit.
- Handles the hazards that operand bypassing cannot resolve:
  - load-use stalls;
  - the multicycle mult/div unit: start pulse, pipeline freeze, completion and timeout;
  - taken-branch/jump flushes.
- Drives the stall/bubble/flush enables for the FD/DX/XM pipeline latches and the start controls of the multdiv unit.

---
 rtl/hazard_sequencer_pkg.sv | 22 ++
 rtl/hazard_sequencer_load_use_detect.sv | 33 +++
 rtl/hazard_sequencer.sv | 144 ++++++++++++++
 tb/tb_hazard_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the hazard sequencer: multdiv FSM state encoding,
// DX control-word field positions and architectural register indices.
package hazard_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StRun   = 2'b10,
    StDone  = 2'b11
  } md_state_e;

  // DX control-word field positions
  localparam int unsigned RD_MSB  = 31;
  localparam int unsigned RD_LSB  = 27;
  localparam int unsigned RWE     = 15;
  localparam int unsigned MEM2REG = 13;

  localparam logic [4:0] ZERO_REG    = 5'd0;
  // Destination of the multdiv result when md_err is set
  localparam logic [4:0] RSTATUS_REG = 5'd30;

endpackage

// File: rtl/hazard_sequencer_load_use_detect.sv
// Load-use hazard detector: flags an FD instruction that reads the register a
// load in DX is about to write. Purely combinational so a wider front end can
// instantiate one per FD slot.
//   rd_dx_i       destination register of the DX instruction
//   rwe_dx_i      DX instruction writes the register file
//   mem2reg_dx_i  DX instruction writes back from memory (a load)
//   rs_fd_i       FD source register rs
//   rt_fd_i       FD source register rt
//   rt_used_fd_i  FD instruction actually reads rt
//   lu_o          load-use hazard present
module load_use_detect
  import hazard_sequencer_pkg::*;
(
  input  logic [4:0] rd_dx_i,
  input  logic       rwe_dx_i,
  input  logic       mem2reg_dx_i,
  input  logic [4:0] rs_fd_i,
  input  logic [4:0] rt_fd_i,
  input  logic       rt_used_fd_i,
  output logic       lu_o
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (rd_dx_i == rs_fd_i);
    rt_match = rt_used_fd_i && (rd_dx_i == rt_fd_i);
    // $0 is hardwired, so a load targeting it never creates a dependency
    lu_o     = mem2reg_dx_i && rwe_dx_i && (rd_dx_i != ZERO_REG) && (rs_match || rt_match);
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller for the 5-stage core. Resolves the hazards
// the operand bypass cannot: load-use stalls, the multicycle multdiv unit
// (start, freeze, completion, timeout) and taken-branch flushes.
//   clock, reset       pipeline clock; asynchronous active-high reset
//   ctrl_dx            DX control word (rd, RWE, mem_to_reg fields used)
//   rs_fd, rt_fd       FD source registers; rt_used_fd qualifies rt
//   is_mult_dx/div_dx  DX opcode is mul / div
//   branch_taken_dx    DX branch/jump resolved taken
//   md_resultRDY       multdiv result pulse; md_exception qualified by it
//   stall_fd/stall_dx  hold the FD / DX latches
//   bubble_dx/xm       load a nop into DX / XM
//   flush_fd           load a nop into FD
//   md_ctrl_MULT/DIV   one-cycle multdiv start pulses
//   md_latch_en        capture the multdiv result into XM
//   md_err             write-back must target $rstatus (registered)
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ctrl_dx,
  input  logic [4:0]  rs_fd,
  input  logic [4:0]  rt_fd,
  input  logic        rt_used_fd,
  input  logic        is_mult_dx,
  input  logic        is_div_dx,
  input  logic        branch_taken_dx,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        bubble_dx,
  output logic        bubble_xm,
  output logic        flush_fd,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic        md_latch_en,
  output logic        md_err
);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_div_q;
  logic             md_err_q;

  logic             lu;
  logic             md_req;
  logic             timeout;
  logic             freeze;

  // Control-word fields this block does not decode
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl_dx[RD_LSB-1:RWE+1], ctrl_dx[RWE-1:MEM2REG+1], ctrl_dx[MEM2REG-1:0]};

  load_use_detect u_load_use_detect (
    .rd_dx_i      (ctrl_dx[RD_MSB:RD_LSB]),
    .rwe_dx_i     (ctrl_dx[RWE]),
    .mem2reg_dx_i (ctrl_dx[MEM2REG]),
    .rs_fd_i      (rs_fd),
    .rt_fd_i      (rt_fd),
    .rt_used_fd_i (rt_used_fd),
    .lu_o         (lu)
  );

  // A multdiv op squashed by a taken branch must never be started
  assign md_req  = (is_mult_dx || is_div_dx) && !branch_taken_dx;
  assign timeout = (cnt_q == CNT_W'(MD_TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      md_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (md_req) begin
            state_q  <= StStart;
            op_div_q <= is_div_dx;
          end
        end
        StStart: begin
          state_q <= StRun;
          cnt_q   <= '0;
        end
        StRun: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A result arriving on the timeout cycle still counts as a result
          if (md_resultRDY) begin
            state_q  <= StDone;
            md_err_q <= md_exception;
          end else if (timeout) begin
            state_q  <= StDone;
            md_err_q <= 1'b1;
          end
        end
        StDone: begin
          // DX instruction advances on this edge, so IDLE sees the next one
          state_q  <= StIdle;
          md_err_q <= 1'b0;
        end
      endcase
    end
  end

  assign freeze = (state_q == StStart) || (state_q == StRun);

  always_comb begin
    stall_fd     = 1'b0;
    stall_dx     = 1'b0;
    bubble_dx    = 1'b0;
    bubble_xm    = 1'b0;
    flush_fd     = 1'b0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    md_latch_en  = 1'b0;
    if (freeze) begin
      stall_fd  = 1'b1;
      stall_dx  = 1'b1;
      bubble_xm = 1'b1;
    end else if (state_q == StIdle) begin
      if (branch_taken_dx) begin
        // PC must take the branch target, so no stall even with a load-use
        flush_fd  = 1'b1;
        bubble_dx = 1'b1;
      end else if (lu) begin
        stall_fd  = 1'b1;
        bubble_dx = 1'b1;
      end
    end
    if (state_q == StStart) begin
      md_ctrl_MULT = !op_div_q;
      md_ctrl_DIV  = op_div_q;
    end
    md_latch_en = (state_q == StDone);
  end

  assign md_err = md_err_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

  localparam int MdTimeout = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ctrl_dx;
  logic [4:0]  rs_fd, rt_fd;
  logic        rt_used_fd, is_mult_dx, is_div_dx, branch_taken_dx;
  logic        md_resultRDY, md_exception;
  logic        stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd;
  logic        md_ctrl_MULT, md_ctrl_DIV, md_latch_en, md_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: an accepted multdiv op is tracked by its age in
  // cycles (1 = start pulse), and the age at which it completes.
  bit m_busy;
  int m_age;
  int m_done_age;
  bit m_err;
  bit m_div;

  int obs_stall, obs_mult, obs_div, obs_latch;

  hazard_sequencer #(
    .MD_TIMEOUT (MdTimeout),
    .CNT_W      (6)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ctrl_dx         (ctrl_dx),
    .rs_fd           (rs_fd),
    .rt_fd           (rt_fd),
    .rt_used_fd      (rt_used_fd),
    .is_mult_dx      (is_mult_dx),
    .is_div_dx       (is_div_dx),
    .branch_taken_dx (branch_taken_dx),
    .md_resultRDY    (md_resultRDY),
    .md_exception    (md_exception),
    .stall_fd        (stall_fd),
    .stall_dx        (stall_dx),
    .bubble_dx       (bubble_dx),
    .bubble_xm       (bubble_xm),
    .flush_fd        (flush_fd),
    .md_ctrl_MULT    (md_ctrl_MULT),
    .md_ctrl_DIV     (md_ctrl_DIV),
    .md_latch_en     (md_latch_en),
    .md_err          (md_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_lu();
    logic [4:0] rd;
    rd = ctrl_dx[31:27];
    return ctrl_dx[13] && ctrl_dx[15] && (rd != 5'd0) &&
           ((rd == rs_fd) || (rt_used_fd && (rd == rt_fd)));
  endfunction

  task automatic model_reset();
    m_busy     = 1'b0;
    m_age      = 0;
    m_done_age = 0;
    m_err      = 1'b0;
    m_div      = 1'b0;
  endtask

  task automatic compare_outputs();
    bit lu, br, idle, frz, st, lat;
    lu   = ref_lu();
    br   = branch_taken_dx;
    idle = !m_busy;
    frz  = m_busy && (m_done_age == 0);
    st   = m_busy && (m_age == 1);
    lat  = m_busy && (m_age == m_done_age);
    check("stall_fd",     32'(stall_fd),     32'(frz || (idle && lu && !br)));
    check("stall_dx",     32'(stall_dx),     32'(frz));
    check("bubble_xm",    32'(bubble_xm),    32'(frz));
    check("bubble_dx",    32'(bubble_dx),    32'(idle && (br || lu)));
    check("flush_fd",     32'(flush_fd),     32'(idle && br));
    check("md_ctrl_MULT", 32'(md_ctrl_MULT), 32'(st && !m_div));
    check("md_ctrl_DIV",  32'(md_ctrl_DIV),  32'(st && m_div));
    check("md_latch_en",  32'(md_latch_en),  32'(lat));
    if (lat) check("md_err", 32'(md_err), 32'(m_err));
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if ((is_mult_dx || is_div_dx) && !branch_taken_dx) begin
        m_busy     = 1'b1;
        m_age      = 1;
        m_done_age = 0;
        m_div      = is_div_dx;
      end
    end else begin
      if (m_age == m_done_age) begin
        m_busy = 1'b0;
      end else if (m_age >= 2 && m_done_age == 0) begin
        // RUN occupies ages 2 .. MdTimeout+1
        if (md_resultRDY) begin
          m_done_age = m_age + 1;
          m_err      = md_exception;
        end else if (m_age == MdTimeout + 1) begin
          m_done_age = m_age + 1;
          m_err      = 1'b1;
        end
      end
      m_age++;
    end
  endtask

  // Called at posedge+1 with inputs already driven
  task automatic cycle();
    @(negedge clock);
    compare_outputs();
    obs_stall += int'(stall_fd);
    obs_mult  += int'(md_ctrl_MULT);
    obs_div   += int'(md_ctrl_DIV);
    obs_latch += int'(md_latch_en);
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_obs();
    obs_stall = 0;
    obs_mult  = 0;
    obs_div   = 0;
    obs_latch = 0;
  endtask

  task automatic quiet_inputs();
    ctrl_dx         = 32'd0;
    rs_fd           = 5'd0;
    rt_fd           = 5'd0;
    rt_used_fd      = 1'b0;
    is_mult_dx      = 1'b0;
    is_div_dx       = 1'b0;
    branch_taken_dx = 1'b0;
    md_resultRDY    = 1'b0;
    md_exception    = 1'b0;
  endtask

  // Runs an accepted op to completion, firing the result at age rdy_age
  // (0 = never). Inputs of the op stay held as the frozen DX would hold them.
  task automatic run_md(input int rdy_age, input bit exc);
    int guard;
    guard = 0;
    cycle();
    while (m_busy && guard < 200) begin
      md_resultRDY = (rdy_age != 0) && (m_age == rdy_age);
      md_exception = exc;
      cycle();
      guard++;
    end
    check("md_bound", 32'(guard < 200), 32'd1);
    quiet_inputs();
    cycle();
  endtask

  task automatic rand_inputs();
    logic [31:0] c;
    c         = $urandom();
    c[31:27]  = 5'($urandom_range(0, 3));
    ctrl_dx   = c;
    rs_fd     = 5'($urandom_range(0, 3));
    rt_fd     = 5'($urandom_range(0, 3));
    rt_used_fd      = 1'($urandom_range(0, 1));
    branch_taken_dx = ($urandom_range(0, 5) == 0);
    if (!m_busy) begin
      is_mult_dx = ($urandom_range(0, 7) == 0);
      is_div_dx  = ($urandom_range(0, 9) == 0);
    end
    md_exception = 1'($urandom_range(0, 1));
    if (m_busy && m_age >= 2 && m_done_age == 0) md_resultRDY = ($urandom_range(0, 29) == 0);
    else md_resultRDY = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    quiet_inputs();
    model_reset();
    clear_obs();
    reset = 1'b1;

    // Reset state
    @(negedge clock);
    compare_outputs();
    check("reset_md_err", 32'(md_err), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Load-use on lw $3 with rs=3: exactly one stall cycle
    clear_obs();
    ctrl_dx = (32'd3 << 27) | (32'd1 << 15) | (32'd1 << 13);
    rs_fd   = 5'd3;
    cycle();
    ctrl_dx = 32'd0;
    cycle();
    check("lu_stall_cycles", 32'(obs_stall), 32'd1);
    // rd=0 load never stalls
    ctrl_dx = (32'd1 << 15) | (32'd1 << 13);
    rs_fd   = 5'd0;
    cycle();
    quiet_inputs();

    // mul, result 33 cycles after START
    clear_obs();
    is_mult_dx = 1'b1;
    run_md(34, 1'b0);
    check("mul_pulses", 32'(obs_mult), 32'd1);
    check("mul_freeze_cycles", 32'(obs_stall), 32'd34);
    check("mul_latch_cycles", 32'(obs_latch), 32'd1);

    // div with exception
    clear_obs();
    is_div_dx = 1'b1;
    run_md(5, 1'b1);
    check("div_pulses", 32'(obs_div), 32'd1);
    check("div_mult_pulses", 32'(obs_mult), 32'd0);

    // Timeout without result
    clear_obs();
    is_mult_dx = 1'b1;
    run_md(0, 1'b0);
    check("timeout_freeze_cycles", 32'(obs_stall), 32'(MdTimeout + 1));

    // Result coincident with the last RUN cycle
    clear_obs();
    is_mult_dx = 1'b1;
    run_md(MdTimeout + 1, 1'b0);
    check("coincident_freeze_cycles", 32'(obs_stall), 32'(MdTimeout + 1));

    // Both opcodes set: div wins
    clear_obs();
    is_mult_dx = 1'b1;
    is_div_dx  = 1'b1;
    run_md(3, 1'b0);
    check("both_div_pulses", 32'(obs_div), 32'd1);

    // Flush overrides load-use; a squashed mul never starts
    clear_obs();
    ctrl_dx         = (32'd3 << 27) | (32'd1 << 15) | (32'd1 << 13);
    rs_fd           = 5'd3;
    branch_taken_dx = 1'b1;
    cycle();
    quiet_inputs();
    is_mult_dx      = 1'b1;
    branch_taken_dx = 1'b1;
    cycle();
    quiet_inputs();
    cycle();
    check("squashed_mul_pulses", 32'(obs_mult), 32'd0);

    // Reset during RUN, then exactly one restart
    is_mult_dx = 1'b1;
    begin
      int guard;
      guard = 0;
      while (!(m_busy && m_age == 11) && guard < 50) begin
        cycle();
        guard++;
      end
      check("run_reach_bound", 32'(guard < 50), 32'd1);
    end
    reset = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    check("midreset_md_err", 32'(md_err), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_obs();
    run_md(4, 1'b0);
    check("restart_pulses", 32'(obs_mult), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
